dm_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data-memory block RAM between the pipeline's M stage (CPU port) and the debug/loader port that fills and inspects memory while the core runs. It sits between the data path's memory stage and the data-memory instance. Each cycle it grants at most one access, stalls the loser, and returns read data tagged to the owner one cycle later.

---
 rtl/dm_arb_pkg.sv | 12 +
 rtl/dm_arb_pick.sv | 35 +++
 rtl/dm_arbiter.sv | 123 ++++++++++++
 tb/tb_dm_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: owner encoding and default widths shared by dm_arbiter, data_path and the debug loader.
`default_nettype none

package dm_arb_pkg;
    localparam logic OWN_CPU   = 1'b0;
    localparam logic OWN_DBG   = 1'b1;
    localparam int   DM_ADDR_W = 8;
    localparam int   DM_DATA_W = 16;
    localparam int   WAIT_W    = 4;
endpackage

`default_nettype wire

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: combinational winner selection for the data-memory arbiter.
// DM_ARB_RR_EN selects round-robin; otherwise fixed CPU priority with a debug wait limit.
`default_nettype none

module dm_arb_pick
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              cpu_req,
    input  logic              dbg_req,
`ifdef DM_ARB_RR_EN
    input  logic              last_owner,
`else
    input  logic [WAIT_W-1:0] wait_cnt,
`endif
    output logic              cpu_gnt,
    output logic              dbg_gnt
);

    logic dbg_first;

`ifdef DM_ARB_RR_EN
    assign dbg_first = (last_owner == OWN_CPU);
`else
    assign dbg_first = (wait_cnt == WAIT_W'(MAX_WAIT));
`endif

    // dbg takes the slot when alone, or when contention favours it.
    assign dbg_gnt = dbg_req & (~cpu_req | dbg_first);
    assign cpu_gnt = cpu_req & ~dbg_gnt;

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data-memory BRAM between the CPU M stage and the debug port.
// Build option DM_ARB_RR_EN: round-robin arbitration instead of fixed CPU priority.
`default_nettype none

module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W   = DM_ADDR_W,
    parameter int DATA_W   = DM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic cpu_req_v;
    logic dbg_req_v;
    logic rd_pend;
    logic rd_owner;

    // Requests are masked while reset is high so every output reads 0 during reset.
    assign cpu_req_v = cpu_req & ~rst;
    assign dbg_req_v = dbg_req & ~rst;

`ifdef DM_ARB_RR_EN
    logic last_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWN_DBG;
        end else if (mem_en) begin
            last_owner <= dbg_gnt ? OWN_DBG : OWN_CPU;
        end
    end

    dm_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .cpu_req    (cpu_req_v),
        .dbg_req    (dbg_req_v),
        .last_owner (last_owner),
        .cpu_gnt    (cpu_gnt),
        .dbg_gnt    (dbg_gnt)
    );
`else
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (dbg_req_v & ~dbg_gnt) begin
            if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    dm_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .cpu_req  (cpu_req_v),
        .dbg_req  (dbg_req_v),
        .wait_cnt (wait_cnt),
        .cpu_gnt  (cpu_gnt),
        .dbg_gnt  (dbg_gnt)
    );
`endif

    assign cpu_stall = cpu_req_v & ~cpu_gnt;
    assign mem_en    = cpu_gnt | dbg_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Read-return pipe: BRAM data arrives one cycle after the granted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_CPU;
        end else begin
            rd_pend  <= mem_en & ~mem_we;
            rd_owner <= dbg_gnt ? OWN_DBG : OWN_CPU;
        end
    end

    assign cpu_rvalid = rd_pend & (rd_owner == OWN_CPU);
    assign dbg_rvalid = rd_pend & (rd_owner == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed self-checking bench for dm_arbiter with a behavioural BRAM.
`default_nettype none

module tb_dm_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic test_reset;
        cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 8'h33; dbg_addr = 8'h44;
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, cpu_stall, cpu_rvalid, dbg_rvalid, mem_en, mem_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected %b",
                     {cpu_gnt, dbg_gnt, cpu_stall, cpu_rvalid, dbg_rvalid, mem_en, mem_we}, 7'b0);
        end
        checks++;
        if ({cpu_rdata, dbg_rdata, mem_addr, mem_wdata} !== 56'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected %h",
                     {cpu_rdata, dbg_rdata, mem_addr, mem_wdata}, 56'h0);
        end
        idle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    // dbg writes used to preload memory, each uncontested and granted in the same cycle
    task automatic test_dbg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        #1;
        checks++;
        if ({dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, a, d}) begin
            errors++;
            $display("FAIL dbg_write_%h: got %h expected %h", a,
                     {dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 1'b1, a, d});
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL dbg_write_rvalid: got %b expected 00", {cpu_rvalid, dbg_rvalid});
        end
    endtask

    task automatic test_cpu_read;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        #1;
        checks++;
        if ({cpu_gnt, cpu_stall, mem_en, mem_we, mem_addr} !== {4'b1010, 8'h10}) begin
            errors++;
            $display("FAIL cpu_read_gnt: got %h expected %h",
                     {cpu_gnt, cpu_stall, mem_en, mem_we, mem_addr}, {4'b1010, 8'h10});
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if ({cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !== {1'b1, 16'hBEEF, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL cpu_read_data: got %h expected %h",
                     {cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata}, {1'b1, 16'hBEEF, 1'b0, 16'h0});
        end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 16'h1234;
        #1;
        checks++;
        if (dbg_gnt !== 1'b1) begin
            errors++;
            $display("FAIL b2b_dbg_gnt: got %b expected 1", dbg_gnt);
        end
        next_cycle();
        idle();
        cpu_req = 1'b1; cpu_addr = 8'h20;
        #1;
        checks++;
        if ({cpu_gnt, dbg_rvalid, cpu_rvalid} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_cpu_gnt: got %b expected 100", {cpu_gnt, dbg_rvalid, cpu_rvalid});
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL b2b_cpu_rdata: got %h expected %h", {cpu_rvalid, cpu_rdata}, {1'b1, 16'h1234});
        end
        next_cycle();
    endtask

    task automatic test_alternate;
        cpu_req = 1'b1; cpu_addr = 8'h01;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL alt_cpu_gnt: got %b expected 1", cpu_gnt);
        end
        next_cycle();
        idle();
        dbg_req = 1'b1; dbg_addr = 8'h02;
        #1;
        checks++;
        if ({dbg_gnt, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !== {2'b11, 16'hAAAA, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL alt_cpu_return: got %h expected %h",
                     {dbg_gnt, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata}, {2'b11, 16'hAAAA, 1'b0, 16'h0});
        end
        next_cycle();
        idle();
        cpu_req = 1'b1; cpu_addr = 8'h01;
        #1;
        checks++;
        if ({cpu_gnt, dbg_rvalid, dbg_rdata, cpu_rvalid, cpu_rdata} !== {2'b11, 16'h5555, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL alt_dbg_return: got %h expected %h",
                     {cpu_gnt, dbg_rvalid, dbg_rdata, cpu_rvalid, cpu_rdata}, {2'b11, 16'h5555, 1'b0, 16'h0});
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if ({cpu_rvalid, cpu_rdata, dbg_rvalid} !== {1'b1, 16'hAAAA, 1'b0}) begin
            errors++;
            $display("FAIL alt_cpu_return2: got %h expected %h",
                     {cpu_rvalid, cpu_rdata, dbg_rvalid}, {1'b1, 16'hAAAA, 1'b0});
        end
        next_cycle();
    endtask

`ifndef DM_ARB_RR_EN
    task automatic test_starvation;
        logic [2:0] exp;
        cpu_req = 1'b1; cpu_addr = 8'h10;
        dbg_req = 1'b1; dbg_addr = 8'h02;
        // a short wait that is withdrawn must not count toward the limit
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({cpu_gnt, dbg_gnt, cpu_stall} !== 3'b100) begin
                errors++;
                $display("FAIL starve_pre_%0d: got %b expected 100", k, {cpu_gnt, dbg_gnt, cpu_stall});
            end
            next_cycle();
        end
        dbg_req = 1'b0;
        next_cycle();
        dbg_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            exp = (k == 5) ? 3'b011 : 3'b100;
            #1;
            checks++;
            if ({cpu_gnt, dbg_gnt, cpu_stall} !== exp) begin
                errors++;
                $display("FAIL starve_cyc_%0d: got %b expected %b", k, {cpu_gnt, dbg_gnt, cpu_stall}, exp);
            end
            next_cycle();
        end
        dbg_req = 1'b0;
        #1;
        checks++;
        if ({cpu_gnt, cpu_stall, dbg_rvalid, dbg_rdata} !== {3'b101, 16'h5555}) begin
            errors++;
            $display("FAIL starve_after: got %h expected %h",
                     {cpu_gnt, cpu_stall, dbg_rvalid, dbg_rdata}, {3'b101, 16'h5555});
        end
        next_cycle();
        dbg_req = 1'b1;
        #1;
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL starve_cleared: got %b expected 10", {cpu_gnt, dbg_gnt});
        end
        next_cycle();
        idle();
        next_cycle();
    endtask
`else
    task automatic test_round_robin;
        logic [1:0] exp;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_addr = 8'h01;
        dbg_req = 1'b1; dbg_addr = 8'h02;
        for (int k = 0; k < 6; k++) begin
            exp = (k % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            checks++;
            if ({cpu_gnt, dbg_gnt} !== exp) begin
                errors++;
                $display("FAIL rr_cyc_%0d: got %b expected %b", k, {cpu_gnt, dbg_gnt}, exp);
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask
`endif

    task automatic test_reset_inflight;
        cpu_req = 1'b1; cpu_addr = 8'h10;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstfl_gnt: got %b expected 1", cpu_gnt);
        end
        next_cycle();
        rst = 1'b1;
        #1;
        checks++;
        if ({cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, mem_en, mem_addr} !== 29'h0) begin
            errors++;
            $display("FAIL rstfl_outputs: got %h expected 0",
                     {cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, mem_en, mem_addr});
        end
        next_cycle();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rstfl_no_rvalid: got %b expected 00", {cpu_rvalid, dbg_rvalid});
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_dbg_write(8'h10, 16'hBEEF);
        test_dbg_write(8'h01, 16'hAAAA);
        test_dbg_write(8'h02, 16'h5555);
        test_cpu_read();
        test_back_to_back();
        test_alternate();
`ifndef DM_ARB_RR_EN
        test_starvation();
`else
        test_round_robin();
`endif
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
